// File: rtl/debug_dump_sequencer_if.sv
// Handshake/bus bundle between the debug dump sequencer, the debug command FSM,
// the register bank / data memory debug read ports and the UART transmitter.
interface debug_dump_sequencer_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_ADDR    = 32,
  parameter int NB_ADDR_RB = 5,
  parameter int NB_ADDR_DM = 7
);
  logic                  i_start;
  logic [1:0]            i_mode;
  logic [NB_ADDR-1:0]    i_pc_value;
  logic [NB_ADDR-1:0]    i_br_data;
  logic [NB_DATA-1:0]    i_dm_data;
  logic                  i_tx_done;
  logic [NB_ADDR_RB-1:0] o_rb_addr;
  logic                  o_rb_read_enable;
  logic [NB_ADDR_DM-1:0] o_dm_addr;
  logic                  o_dm_read_enable;
  logic [NB_DATA-1:0]    o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    input  i_start, i_mode, i_pc_value, i_br_data, i_dm_data, i_tx_done,
    output o_rb_addr, o_rb_read_enable, o_dm_addr, o_dm_read_enable,
           o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_mode, i_pc_value, i_br_data, i_dm_data, i_tx_done,
    input  o_rb_addr, o_rb_read_enable, o_dm_addr, o_dm_read_enable,
           o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: streams the PC, the register bank and/or data memory
// to the UART transmitter, LSB first, one byte per TX handshake.
module debug_dump_sequencer #(
  parameter int NB_DATA     = 8,
  parameter int NB_ADDR     = 32,
  parameter int NB_ADDR_RB  = 5,
  parameter int N_REGS      = 32,
  parameter int NB_ADDR_DM  = 7,
  parameter int DM_DEPTH    = 128,
  parameter int BYTES_IN_32 = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  debug_dump_sequencer_if.master dbg
);
  localparam int NB_CNT  = (NB_ADDR_DM > NB_ADDR_RB) ? NB_ADDR_DM : NB_ADDR_RB;
  localparam int NB_BYTE = (BYTES_IN_32 > 1) ? $clog2(BYTES_IN_32) : 1;
  localparam logic [NB_CNT-1:0]  LAST_REG  = NB_CNT'(N_REGS - 1);
  localparam logic [NB_CNT-1:0]  LAST_DM   = NB_CNT'(DM_DEPTH - 1);
  localparam logic [NB_BYTE-1:0] LAST_BYTE = NB_BYTE'(BYTES_IN_32 - 1);

  localparam logic [1:0] MODE_REGS = 2'd0;
  localparam logic [1:0] MODE_PC   = 2'd1;
  localparam logic [1:0] MODE_DM   = 2'd2;
  localparam logic [1:0] MODE_ALL  = 2'd3;

  typedef enum logic [1:0] {
    SEC_PC   = 2'd0,
    SEC_REGS = 2'd1,
    SEC_DM   = 2'd2
  } section_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic section_e first_section(input logic [1:0] mode);
    section_e sec;
    case (mode)
      MODE_REGS: sec = SEC_REGS;
      MODE_PC:   sec = SEC_PC;
      MODE_DM:   sec = SEC_DM;
      default:   sec = SEC_PC;
    endcase
    return sec;
  endfunction

  state_e              state_r, state_nxt_s;
  section_e            section_r, section_nxt_s, sec_next_s;
  logic [1:0]          mode_r, mode_nxt_s;
  logic [NB_ADDR-1:0]  pc_snap_r, pc_snap_nxt_s;
  logic [NB_ADDR-1:0]  shift_r, shift_nxt_s;
  logic [NB_CNT-1:0]   word_cnt_r, word_cnt_nxt_s;
  logic [NB_BYTE-1:0]  byte_cnt_r, byte_cnt_nxt_s;
  logic                byte_more_s, word_more_s, sec_more_s;

  logic [NB_ADDR_RB-1:0] rb_addr_r, rb_addr_nxt_s;
  logic [NB_ADDR_DM-1:0] dm_addr_r, dm_addr_nxt_s;
  logic [NB_DATA-1:0]    tx_data_r, tx_data_nxt_s;
  logic rb_re_r, rb_re_nxt_s, dm_re_r, dm_re_nxt_s;
  logic tx_start_r, tx_start_nxt_s, busy_r, busy_nxt_s, done_r, done_nxt_s;

  // Section bookkeeping: what is left in the current word, section and mode.
  always_comb begin
    byte_more_s = 1'b0;
    word_more_s = 1'b0;
    sec_more_s  = 1'b0;
    sec_next_s  = section_r;
    case (section_r)
      SEC_REGS: begin
        byte_more_s = (byte_cnt_r != LAST_BYTE);
        word_more_s = (word_cnt_r != LAST_REG);
      end
      SEC_DM: begin
        byte_more_s = 1'b0;
        word_more_s = (word_cnt_r != LAST_DM);
      end
      default: begin
        byte_more_s = (byte_cnt_r != LAST_BYTE);
        word_more_s = 1'b0;
      end
    endcase
    if (mode_r == MODE_ALL) begin
      case (section_r)
        SEC_PC: begin
          sec_more_s = 1'b1;
          sec_next_s = SEC_REGS;
        end
        SEC_REGS: begin
          sec_more_s = 1'b1;
          sec_next_s = SEC_DM;
        end
        default: begin
          sec_more_s = 1'b0;
          sec_next_s = section_r;
        end
      endcase
    end else begin
      sec_more_s = 1'b0;
      sec_next_s = section_r;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      section_r  <= SEC_PC;
      mode_r     <= 2'd0;
      pc_snap_r  <= {NB_ADDR{1'b0}};
      shift_r    <= {NB_ADDR{1'b0}};
      word_cnt_r <= {NB_CNT{1'b0}};
      byte_cnt_r <= {NB_BYTE{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      section_r  <= section_nxt_s;
      mode_r     <= mode_nxt_s;
      pc_snap_r  <= pc_snap_nxt_s;
      shift_r    <= shift_nxt_s;
      word_cnt_r <= word_cnt_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
    end
  end

  // Next state plus the counter/shift-register updates that go with each transition.
  always_comb begin
    state_nxt_s    = state_r;
    section_nxt_s  = section_r;
    mode_nxt_s     = mode_r;
    pc_snap_nxt_s  = pc_snap_r;
    shift_nxt_s    = shift_r;
    word_cnt_nxt_s = word_cnt_r;
    byte_cnt_nxt_s = byte_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (dbg.i_start) begin
          mode_nxt_s     = dbg.i_mode;
          pc_snap_nxt_s  = dbg.i_pc_value;
          section_nxt_s  = first_section(dbg.i_mode);
          word_cnt_nxt_s = {NB_CNT{1'b0}};
          byte_cnt_nxt_s = {NB_BYTE{1'b0}};
          state_nxt_s    = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_CAPTURE;
      ST_CAPTURE: begin
        case (section_r)
          SEC_REGS: shift_nxt_s = dbg.i_br_data;
          SEC_DM:   shift_nxt_s = {{(NB_ADDR - NB_DATA){1'b0}}, dbg.i_dm_data};
          default:  shift_nxt_s = pc_snap_r;
        endcase
        state_nxt_s = ST_SEND;
      end
      ST_SEND: state_nxt_s = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (!dbg.i_tx_done) begin
          state_nxt_s = ST_WAIT_TX;
        end else if (byte_more_s) begin
          shift_nxt_s    = shift_r >> NB_DATA;
          byte_cnt_nxt_s = byte_cnt_r + NB_BYTE'(1);
          state_nxt_s    = ST_SEND;
        end else if (word_more_s) begin
          word_cnt_nxt_s = word_cnt_r + NB_CNT'(1);
          byte_cnt_nxt_s = {NB_BYTE{1'b0}};
          state_nxt_s    = ST_FETCH;
        end else if (sec_more_s) begin
          section_nxt_s  = sec_next_s;
          word_cnt_nxt_s = {NB_CNT{1'b0}};
          byte_cnt_nxt_s = {NB_BYTE{1'b0}};
          state_nxt_s    = ST_FETCH;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without lag.
  always_comb begin
    rb_addr_nxt_s  = rb_addr_r;
    dm_addr_nxt_s  = dm_addr_r;
    tx_data_nxt_s  = tx_data_r;
    rb_re_nxt_s    = 1'b0;
    dm_re_nxt_s    = 1'b0;
    tx_start_nxt_s = 1'b0;
    busy_nxt_s     = 1'b0;
    done_nxt_s     = 1'b0;
    case (state_nxt_s)
      ST_FETCH: begin
        busy_nxt_s = 1'b1;
        if (section_nxt_s == SEC_REGS) begin
          rb_addr_nxt_s = word_cnt_nxt_s[NB_ADDR_RB-1:0];
          rb_re_nxt_s   = 1'b1;
        end else if (section_nxt_s == SEC_DM) begin
          dm_addr_nxt_s = word_cnt_nxt_s[NB_ADDR_DM-1:0];
          dm_re_nxt_s   = 1'b1;
        end else begin
          rb_re_nxt_s = 1'b0;
          dm_re_nxt_s = 1'b0;
        end
      end
      ST_CAPTURE, ST_WAIT_TX: busy_nxt_s = 1'b1;
      ST_SEND: begin
        busy_nxt_s     = 1'b1;
        tx_start_nxt_s = 1'b1;
        tx_data_nxt_s  = shift_nxt_s[NB_DATA-1:0];
      end
      ST_DONE: done_nxt_s = 1'b1;
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rb_addr_r  <= {NB_ADDR_RB{1'b0}};
      dm_addr_r  <= {NB_ADDR_DM{1'b0}};
      tx_data_r  <= {NB_DATA{1'b0}};
      rb_re_r    <= 1'b0;
      dm_re_r    <= 1'b0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rb_addr_r  <= rb_addr_nxt_s;
      dm_addr_r  <= dm_addr_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      rb_re_r    <= rb_re_nxt_s;
      dm_re_r    <= dm_re_nxt_s;
      tx_start_r <= tx_start_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign dbg.o_rb_addr        = rb_addr_r;
  assign dbg.o_rb_read_enable = rb_re_r;
  assign dbg.o_dm_addr        = dm_addr_r;
  assign dbg.o_dm_read_enable = dm_re_r;
  assign dbg.o_tx_data        = tx_data_r;
  assign dbg.o_tx_start       = tx_start_r;
  assign dbg.o_busy           = busy_r;
  assign dbg.o_done           = done_r;
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer: expected bytes/addresses are queued
// by the stimulus, a negedge monitor pops and compares whatever the DUT emits.
module tb_debug_dump_sequencer;
  logic i_clock = 1'b0;
  logic i_reset;
  debug_dump_sequencer_if dbg ();

  debug_dump_sequencer dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .dbg     (dbg)
  );

  always #5 i_clock = ~i_clock;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int rb_q[$];
  int dm_q[$];
  int done_cnt = 0;
  int bytes_sent = 0;
  int tx_done_cnt = 0;
  logic tx_done_model = 1'b0;
  logic spur_done = 1'b0;
  logic [31:0] regs_m[32];
  logic [7:0]  dm_m[128];

  assign dbg.i_tx_done = tx_done_model | spur_done;

  // One-cycle-latency read models of the register bank and data memory.
  always @(posedge i_clock) begin
    if (dbg.o_rb_read_enable) dbg.i_br_data <= regs_m[dbg.o_rb_addr];
    if (dbg.o_dm_read_enable) dbg.i_dm_data <= dm_m[dbg.o_dm_addr];
    if (tx_done_model) tx_done_cnt <= tx_done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {7'd0, dbg.o_tx_start, dbg.o_busy, dbg.o_done, dbg.o_rb_read_enable,
            dbg.o_dm_read_enable, dbg.o_tx_data, dbg.o_rb_addr, dbg.o_dm_addr};
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  // UART TX model: i_tx_done five cycles after each start pulse.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        cnt = 0;
        tx_done_model = 1'b0;
      end else if (dbg.o_tx_start) begin
        cnt = 5;
        tx_done_model = 1'b0;
      end else if (cnt == 1) begin
        cnt = 0;
        tx_done_model = 1'b1;
      end else begin
        if (cnt != 0) cnt = cnt - 1;
        tx_done_model = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard queues whenever the DUT emits a byte or a read.
  initial begin
    logic outstanding;
    int done_mark;
    outstanding = 1'b0;
    done_mark = 0;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        outstanding = 1'b0;
      end else begin
        if (dbg.o_tx_start) begin
          check("tx_start_after_done", (!outstanding) || (tx_done_cnt != done_mark), 1);
          outstanding = 1'b1;
          done_mark = tx_done_cnt;
          bytes_sent++;
          check("byte_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("tx_data", dbg.o_tx_data, exp_q.pop_front());
        end
        if (dbg.o_rb_read_enable) begin
          check("rb_read_expected", rb_q.size() != 0, 1);
          if (rb_q.size() != 0) check("rb_addr", dbg.o_rb_addr, rb_q.pop_front());
        end
        if (dbg.o_dm_read_enable) begin
          check("dm_read_expected", dm_q.size() != 0, 1);
          if (dm_q.size() != 0) check("dm_addr", dbg.o_dm_addr, dm_q.pop_front());
        end
        if (dbg.o_done) begin
          done_cnt++;
          check("busy_low_in_done", dbg.o_busy, 0);
        end
      end
    end
  end

  task automatic do_start(input logic [1:0] m);
    @(negedge i_clock);
    dbg.i_start = 1'b1;
    dbg.i_mode  = m;
    @(negedge i_clock);
    dbg.i_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
    repeat (10) @(negedge i_clock);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_rb_left"}, rb_q.size(), 0);
    check({name, "_dm_left"}, dm_q.size(), 0);
    check({name, "_idle_busy"}, dbg.o_busy, 0);
  endtask

  initial begin
    int d0;
    int b0;
    int n;
    logic found;
    i_reset = 1'b1;
    dbg.i_start = 1'b0;
    dbg.i_mode = 2'd0;
    dbg.i_pc_value = 32'h0;
    for (int i = 0; i < 32; i++) regs_m[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 128; i++) dm_m[i] = ~8'(i);

    // 1: reset state, idle with spurious tx_done
    repeat (3) @(negedge i_clock);
    check("reset_outputs", out_vec(), 0);
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clock);
      spur_done = (i == 5 || i == 12) ? 1'b1 : 1'b0;
      check("idle_outputs", out_vec(), 0);
    end
    spur_done = 1'b0;
    check("idle_no_done", done_cnt, 0);

    // 2: PC dump, latency and snapshot
    dbg.i_pc_value = 32'h1234_5678;
    push_word(32'h1234_5678);
    @(negedge i_clock);
    dbg.i_start = 1'b1;
    dbg.i_mode = 2'd1;
    @(negedge i_clock);
    dbg.i_start = 1'b0;
    dbg.i_mode = 2'd2;
    check("pc_fetch_busy", dbg.o_busy, 1);
    check("pc_fetch_no_tx", dbg.o_tx_start, 0);
    check("pc_fetch_no_read", {dbg.o_rb_read_enable, dbg.o_dm_read_enable}, 0);
    @(negedge i_clock);
    check("pc_capture_no_tx", dbg.o_tx_start, 0);
    @(negedge i_clock);
    check("pc_first_tx_latency", dbg.o_tx_start, 1);
    check("pc_first_byte", dbg.o_tx_data, 32'h78);
    dbg.i_pc_value = 32'hDEAD_BEEF;
    wait_done("pc", 200);

    // 3: register bank dump
    for (int i = 0; i < 32; i++) begin
      push_word(32'hA000_0000 + 32'(i));
      rb_q.push_back(i);
    end
    do_start(2'd0);
    wait_done("regs", 3000);

    // 4: data memory dump
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(~8'(i));
      dm_q.push_back(i);
    end
    do_start(2'd2);
    wait_done("dm", 3000);

    // 5: ALL dump with a second start while busy and a spurious done in FETCH
    dbg.i_pc_value = 32'hCAFE_F00D;
    push_word(32'hCAFE_F00D);
    for (int i = 0; i < 32; i++) begin
      push_word(32'hA000_0000 + 32'(i));
      rb_q.push_back(i);
    end
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(~8'(i));
      dm_q.push_back(i);
    end
    do_start(2'd3);
    fork
      wait_done("all", 5000);
      begin
        repeat (20) @(negedge i_clock);
        dbg.i_start = 1'b1;
        dbg.i_mode = 2'd2;
        @(negedge i_clock);
        dbg.i_start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
          @(negedge i_clock);
          n++;
          if (dbg.o_rb_read_enable) found = 1'b1;
        end
        check("all_fetch_seen", found, 1);
        spur_done = 1'b1;
        @(negedge i_clock);
        spur_done = 1'b0;
      end
    join

    // 6: reset in the middle of a REGS dump, then a clean PC dump
    for (int i = 0; i < 32; i++) begin
      push_word(32'hA000_0000 + 32'(i));
      rb_q.push_back(i);
    end
    b0 = bytes_sent;
    do_start(2'd0);
    n = 0;
    while (bytes_sent < b0 + 10 && n < 500) begin
      @(negedge i_clock);
      n++;
    end
    check("reset_ten_bytes_sent", bytes_sent - b0, 10);
    d0 = done_cnt;
    i_reset = 1'b1;
    @(negedge i_clock);
    check("midreset_outputs", out_vec(), 0);
    @(negedge i_clock);
    i_reset = 1'b0;
    exp_q.delete();
    rb_q.delete();
    dm_q.delete();
    repeat (10) @(negedge i_clock);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_idle", out_vec(), 0);
    dbg.i_pc_value = 32'h89AB_CDEF;
    push_word(32'h89AB_CDEF);
    do_start(2'd1);
    wait_done("pc_after_reset", 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Serializes processor debug state onto the UART TX byte interface after a halt or on a host command: PC, register bank, data memory, or all three in sequence.
- Sits between the debug command FSM (which issues i_start/i_mode) and the UART transmitter.
- Owns the register-bank and data-memory debug read ports while busy.
- Performs all addressing, read-latency alignment, byte slicing and TX handshaking.

Parameters:
- NB_DATA, 8, UART byte width.
- NB_ADDR, 32, PC / register word width.
- NB_ADDR_RB, 5, register bank address width.
- N_REGS, 32, registers dumped.
- NB_ADDR_DM, 7, data memory address width.
- DM_DEPTH, 128, data memory bytes dumped.
- BYTES_IN_32, 4, bytes per 32-bit word.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  dump request; sampled only in IDLE.
- i_mode  in  2  dump selection, sampled with i_start: 0=REGS, 1=PC, 2=DM, 3=ALL (PC, then REGS, then DM).
- i_pc_value  in  NB_ADDR  current PC.
- i_br_data  in  NB_ADDR  register bank read data, 1-cycle latency.
- i_dm_data  in  NB_DATA  data memory read data, 1-cycle latency.
- i_tx_done  in  1  UART TX finished current byte (1-cycle pulse).
- o_rb_addr  out  NB_ADDR_RB  register bank read address.
- o_rb_read_enable  out  1  register bank read strobe.
- o_dm_addr  out  NB_ADDR_DM  data memory read address.
- o_dm_read_enable  out  1  data memory read strobe.
- o_tx_data  out  NB_DATA  byte to transmit.
- o_tx_start  out  1  TX start pulse.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse at dump completion.

Behaviour:
Clocking and reset
- i_clock, rising edge. i_reset synchronous, active-high.
- On reset, all outputs are 0, the FSM is in IDLE, and all counters are cleared.
- Reset mid-dump aborts immediately with no o_done.

States
- IDLE: o_busy=0. On i_start, latch i_mode and snapshot i_pc_value into the PC capture register, set section = first section of the mode, clear the word and byte counters, then go to FETCH.
- FETCH (1 cycle): drive the address for the current word:
  - REGS: o_rb_addr = word count, o_rb_read_enable=1.
  - DM: o_dm_addr = word count, o_dm_read_enable=1.
  - PC: no read.
  - Go to CAPTURE.
- CAPTURE (1 cycle): load the 32-bit shift register:
  - REGS: i_br_data.
  - DM: {24'b0, i_dm_data}.
  - PC: the PC snapshot.
  - Go to SEND.
- SEND (1 cycle): o_tx_start=1, o_tx_data = shift register [7:0]. Go to WAIT_TX.
- WAIT_TX: o_tx_data is held stable; o_tx_start=0. On i_tx_done:
  - More bytes remain in the word (PC/REGS: byte count < 3): shift right 8, byte count+1, go to SEND.
  - Else, more words remain in the section: word count+1, byte count=0, go to FETCH.
  - Else, a next section exists (ALL: PC→REGS→DM): switch section, clear counters, go to FETCH.
  - Else go to DONE.
- DONE (1 cycle): o_done=1, o_busy=0, go to IDLE.

Byte order and section sizes
- Bytes are sent LSB first.
- DM sends exactly 1 byte per address.
- Section sizes: PC 4 bytes; REGS 128 bytes (32×4); DM 128 bytes; ALL 260 bytes.

Handshake and timing
- o_tx_start is never asserted twice without an intervening i_tx_done.
- Latency: i_start sampled at edge 0 gives o_tx_start high in the cycle after edge 2 (FETCH, CAPTURE, SEND).
- Next byte of the same word: 1 cycle after i_tx_done.
- Next word: 3 cycles after i_tx_done.
- Last byte's i_tx_done at edge n gives o_done high for exactly one cycle after edge n.
- o_busy is high from the cycle after i_start is accepted through WAIT_TX; it is low in DONE and IDLE.

Boundary conditions
- i_start while busy: ignored.
- i_mode changes while busy: ignored.
- i_tx_done outside WAIT_TX: ignored.
- i_pc_value changes during a dump: no effect; the snapshot is used.
- Word counter and addresses never wrap past N_REGS-1 / DM_DEPTH-1; the last address is followed by a section change or DONE.
- Read enables are high only in FETCH; the addresses hold their value otherwise.

Test Plan:
1. Reset then idle: with no stimulus, o_tx_start, o_busy, o_done, o_rb_read_enable and o_dm_read_enable stay 0 for 20 cycles. i_tx_done pulses are ignored.
2. PC dump: i_pc_value=0x12345678, i_start with mode=1, TX model returns i_tx_done 5 cycles after each start. Required: bytes 0x78,0x56,0x34,0x12; first o_tx_start 3 cycles after i_start; exactly one o_done; PC changed mid-dump has no effect.
3. REGS dump: register model r[i]=0xA0000000+i. Required: 128 bytes; reg 5 yields 05 00 00 A0; o_rb_addr sequences 0..31 with one read strobe per register.
4. DM dump: dm[i]=~i. Required: 128 bytes FF,FE,...,80; o_dm_addr 0..127; no address 128 is ever driven; o_done after the 128th i_tx_done.
5. ALL dump: required 260 bytes in order PC, REGS, DM. A second i_start during busy changes nothing; a spurious i_tx_done during FETCH is ignored.
6. Reset mid-dump: assert i_reset after 10 bytes of REGS. Required: all outputs 0 the next cycle, no o_done. A fresh i_start with mode=1 then sends 4 correct PC bytes.
